// File: rtl/r200lsu_pkg.sv
// Shared definitions for the r200 load/store unit: RV32 width codes,
// FSM state encoding and the request legality/alignment check.
package r200lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,
    LSU_BUSY = 2'd1,
    LSU_DONE = 2'd2
  } lsu_state_e;

  // Stores only accept the signed width codes; unsigned variants are load-only.
  function automatic logic req_legal(input logic       is_store,
                                     input logic [2:0] func3,
                                     input logic [1:0] addr_lo);
    logic ok;
    case (func3)
      F3_B:         ok = 1'b1;
      F3_H:         ok = ~addr_lo[0];
      F3_W:         ok = (addr_lo == 2'b00);
      F3_BU:        ok = ~is_store;
      F3_HU:        ok = ~is_store & ~addr_lo[0];
      default:      ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/r200lsu_align.sv
// Byte-lane steering for stores and lane extraction / extension for loads.
// Purely combinational; the caller supplies the relevant address bits.
module r200lsu_align
  import r200lsu_pkg::*;
(
  input  logic [2:0]  i_st_func3,
  input  logic [1:0]  i_st_addr,
  input  logic [31:0] i_st_data,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  input  logic [2:0]  i_ld_func3,
  input  logic [1:0]  i_ld_addr,
  input  logic [31:0] i_ld_rdata,
  output logic [31:0] o_ld_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // NOTE: every output of an always_comb gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    o_be    = 4'b1111;
    o_wdata = i_st_data;
    case (i_st_func3[1:0])
      2'b00: begin
        o_be    = 4'b0001 << i_st_addr;
        o_wdata = {4{i_st_data[7:0]}};
      end
      2'b01: begin
        o_be    = i_st_addr[1] ? 4'b1100 : 4'b0011;
        o_wdata = {2{i_st_data[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    case (i_ld_addr)
      2'b00:   w_byte = i_ld_rdata[7:0];
      2'b01:   w_byte = i_ld_rdata[15:8];
      2'b10:   w_byte = i_ld_rdata[23:16];
      default: w_byte = i_ld_rdata[31:24];
    endcase
    w_half = i_ld_addr[1] ? i_ld_rdata[31:16] : i_ld_rdata[15:0];
  end

  always_comb begin
    case (i_ld_func3)
      F3_B:    o_ld_data = {{24{w_byte[7]}}, w_byte};
      F3_H:    o_ld_data = {{16{w_half[15]}}, w_half};
      F3_BU:   o_ld_data = {24'd0, w_byte};
      F3_HU:   o_ld_data = {16'd0, w_half};
      default: o_ld_data = i_ld_rdata;
    endcase
  end

endmodule

// File: rtl/r200lsu.sv
// Memory-stage load/store unit: accepts one access from execute, runs it on the
// req/ack data bus with a timeout, stalls the pipeline meanwhile, returns loads.
module r200lsu
  import r200lsu_pkg::*;
#(
  parameter int ACK_TIMEOUT = 255,
  parameter int CNT_W       = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_memrd,
  input  logic        req_memwr,
  input  logic [2:0]  req_func3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [4:0]  req_rdaddr,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic        stall,
  output logic        ld_valid,
  output logic [31:0] ld_data,
  output logic [4:0]  ld_rdaddr,
  output logic        misalign_err,
  output logic        bus_err
);

  lsu_state_e       r_state, w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_func3;
  logic [1:0]       r_addr_lo;
  logic [4:0]       r_rdaddr;
  logic [31:0]      r_bus_addr, r_bus_wdata, r_ld_data;
  logic [3:0]       r_bus_be;
  logic             r_bus_we, r_ld_valid, r_misalign_err, r_bus_err;

  logic             w_req, w_ok, w_accept, w_reject, w_timeout;
  logic [3:0]       w_be;
  logic [31:0]      w_wdata, w_ld_ext;

  assign w_req     = req_valid & (req_memrd | req_memwr);
  assign w_ok      = req_legal(req_memwr, req_func3, req_addr[1:0]);
  assign w_accept  = (r_state == LSU_IDLE) & w_req & w_ok;
  assign w_reject  = (r_state == LSU_IDLE) & w_req & ~w_ok;
  assign w_timeout = ~bus_ack & (r_cnt == CNT_W'(ACK_TIMEOUT - 1));

  r200lsu_align u_align (
    .i_st_func3 (req_func3),
    .i_st_addr  (req_addr[1:0]),
    .i_st_data  (req_wdata),
    .o_be       (w_be),
    .o_wdata    (w_wdata),
    .i_ld_func3 (r_func3),
    .i_ld_addr  (r_addr_lo),
    .i_ld_rdata (bus_rdata),
    .o_ld_data  (w_ld_ext)
  );

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) r_state <= LSU_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      LSU_IDLE: if (w_accept) w_next = LSU_BUSY;
      LSU_BUSY: if (bus_ack || w_timeout) w_next = LSU_DONE;
      LSU_DONE: w_next = LSU_IDLE;
      default:  w_next = LSU_IDLE;
    endcase
  end

  // Accept-cycle stall is combinational so execute does not advance past a load.
  always_comb begin
    bus_req = (r_state == LSU_BUSY);
    stall   = (r_state == LSU_BUSY) | w_accept;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt          <= '0;
      r_func3        <= '0;
      r_addr_lo      <= '0;
      r_rdaddr       <= '0;
      r_bus_addr     <= '0;
      r_bus_be       <= '0;
      r_bus_wdata    <= '0;
      r_bus_we       <= 1'b0;
      r_ld_data      <= '0;
      r_ld_valid     <= 1'b0;
      r_misalign_err <= 1'b0;
      r_bus_err      <= 1'b0;
    end else begin
      r_ld_valid     <= 1'b0;
      r_bus_err      <= 1'b0;
      r_misalign_err <= w_reject;
      if (w_accept) begin
        r_cnt       <= '0;
        r_func3     <= req_func3;
        r_addr_lo   <= req_addr[1:0];
        r_rdaddr    <= req_rdaddr;
        r_bus_addr  <= {req_addr[31:2], 2'b00};
        r_bus_be    <= w_be;
        r_bus_wdata <= w_wdata;
        r_bus_we    <= req_memwr;
      end
      if (r_state == LSU_BUSY) begin
        r_cnt <= r_cnt + CNT_W'(1);
        if (bus_ack) begin
          if (!r_bus_we) begin
            r_ld_data  <= w_ld_ext;
            r_ld_valid <= 1'b1;
          end
        end else if (w_timeout) begin
          r_bus_err <= 1'b1;
        end
      end
    end
  end

  assign bus_we       = r_bus_we;
  assign bus_addr     = r_bus_addr;
  assign bus_be       = r_bus_be;
  assign bus_wdata    = r_bus_wdata;
  assign ld_valid     = r_ld_valid;
  assign ld_data      = r_ld_data;
  assign ld_rdaddr    = r_rdaddr;
  assign misalign_err = r_misalign_err;
  assign bus_err      = r_bus_err;

endmodule

// File: tb/tb_r200lsu.sv
// Scoreboard bench for r200lsu: the driver pushes expected bus beats and
// completion events; a negedge monitor pops and compares them as they appear.
module tb_r200lsu;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_memrd, req_memwr;
  logic [2:0]  req_func3;
  logic [31:0] req_addr, req_wdata;
  logic [4:0]  req_rdaddr;
  logic        bus_req, bus_we, bus_ack;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_be;
  logic        stall, ld_valid, misalign_err, bus_err;
  logic [31:0] ld_data;
  logic [4:0]  ld_rdaddr;

  r200lsu #(.ACK_TIMEOUT(TO), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_memrd(req_memrd), .req_memwr(req_memwr),
    .req_func3(req_func3), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_rdaddr(req_rdaddr),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
    .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata),
    .stall(stall), .ld_valid(ld_valid), .ld_data(ld_data), .ld_rdaddr(ld_rdaddr),
    .misalign_err(misalign_err), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  // Event vector bits: {ld_valid, bus_err, misalign_err}
  typedef struct {
    logic [2:0]  ev;
    logic [31:0] data;
    logic [4:0]  rd;
  } res_t;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic        we;
    logic [31:0] wdata;
  } bus_t;

  res_t res_q[$];
  bus_t bus_q[$];
  bus_t cur_bus;
  int   n_checks = 0;
  int   n_errors = 0;
  int   stall_cnt = 0;
  int   req_cnt = 0;
  logic prev_req = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic model_legal(input logic wr, input logic [2:0] f3, input logic [31:0] a);
    int size;
    logic ok;
    if (wr) ok = f3 inside {3'd0, 3'd1, 3'd2};
    else    ok = f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    size = 1 << f3[1:0];
    return ok && ((int'(a[1:0]) % size) == 0);
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [1:0] a,
                                             input logic [31:0] rdata);
    logic [31:0] lane;
    lane = rdata >> (8 * a);
    case (f3)
      3'd0:    return {{24{lane[7]}}, lane[7:0]};
      3'd1:    return {{16{lane[15]}}, lane[15:0]};
      3'd4:    return {24'd0, lane[7:0]};
      3'd5:    return {16'd0, lane[15:0]};
      default: return rdata;
    endcase
  endfunction

  function automatic bus_t model_bus(input logic wr, input logic [2:0] f3,
                                     input logic [31:0] a, input logic [31:0] wd);
    bus_t b;
    int   size;
    int   lo;
    size    = 1 << f3[1:0];
    lo      = int'(a[1:0]);
    b.addr  = {a[31:2], 2'b00};
    b.we    = wr;
    b.be    = '0;
    b.wdata = '0;
    for (int i = 0; i < 4; i++) begin
      b.be[i]         = (i >= lo) && (i < lo + size);
      b.wdata[8*i +: 8] = wd[8*(i % size) +: 8];
    end
    if (!wr) b.wdata = '0;
    return b;
  endfunction

  // Monitor: completion events, bus beats held stable while bus_req is high.
  always @(negedge clk) begin
    logic [2:0] ev;
    res_t e;
    ev = {ld_valid, bus_err, misalign_err};
    if (ev != 3'b000) begin
      if (res_q.size() == 0) check("stray_event", 32'(ev), 32'd0);
      else begin
        e = res_q.pop_front();
        check("event", 32'(ev), 32'(e.ev));
        if (e.ev[2]) begin
          check("ld_data", ld_data, e.data);
          check("ld_rdaddr", 32'(ld_rdaddr), 32'(e.rd));
        end
      end
    end
    if (bus_req && !prev_req) begin
      if (bus_q.size() == 0) check("stray_bus_req", 32'(bus_req), 32'd0);
      else cur_bus = bus_q.pop_front();
    end
    if (bus_req) begin
      check("bus_addr", bus_addr, cur_bus.addr);
      check("bus_be", 32'(bus_be), 32'(cur_bus.be));
      check("bus_we", 32'(bus_we), 32'(cur_bus.we));
      if (cur_bus.we) check("bus_wdata", bus_wdata, cur_bus.wdata);
      req_cnt++;
    end
    if (stall) stall_cnt++;
    prev_req = bus_req;
  end

  // ack_wait: cycles after bus_req rises before ack; negative means never ack.
  task automatic op(input logic rd, input logic wr, input logic [2:0] f3,
                    input logic [31:0] a, input logic [31:0] wd, input logic [4:0] rdn,
                    input logic [31:0] rdata, input int ack_wait, input string tag);
    logic ok;
    res_t r;
    ok        = model_legal(wr, f3, a);
    stall_cnt = 0;
    req_cnt   = 0;
    @(posedge clk); #1;
    req_valid = 1'b1; req_memrd = rd; req_memwr = wr; req_func3 = f3;
    req_addr = a; req_wdata = wd; req_rdaddr = rdn;
    if (!ok) begin
      r.ev = 3'b001; r.data = '0; r.rd = '0;
      res_q.push_back(r);
    end else begin
      bus_q.push_back(model_bus(wr, f3, a, wd));
      if (ack_wait < 0) begin
        r.ev = 3'b010; r.data = '0; r.rd = '0;
        res_q.push_back(r);
      end else if (!wr) begin
        r.ev = 3'b100; r.data = model_load(f3, a[1:0], rdata); r.rd = rdn;
        res_q.push_back(r);
      end
    end
    @(posedge clk); #1;
    req_valid = 1'b0; req_memrd = 1'b0; req_memwr = 1'b0;
    if (ok && ack_wait >= 0) begin
      repeat (ack_wait) @(posedge clk);
      #1;
      bus_ack = 1'b1; bus_rdata = rdata;
      @(posedge clk); #1;
      bus_ack = 1'b0; bus_rdata = $urandom;
    end
    repeat (TO + 3) @(posedge clk);
    #1;
    check({tag, "_stall_cycles"}, 32'(stall_cnt),
          !ok ? 32'd0 : (ack_wait < 0 ? 32'(TO + 1) : 32'(ack_wait + 2)));
    check({tag, "_req_cycles"}, 32'(req_cnt),
          !ok ? 32'd0 : (ack_wait < 0 ? 32'(TO) : 32'(ack_wait + 1)));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_memrd = 1'b0; req_memwr = 1'b0;
    req_func3 = '0; req_addr = '0; req_wdata = '0; req_rdaddr = '0;
    bus_ack = 1'b0; bus_rdata = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_bus_req", 32'(bus_req), 32'd0);
    check("rst_bus_we", 32'(bus_we), 32'd0);
    check("rst_bus_addr", bus_addr, 32'd0);
    check("rst_bus_be", 32'(bus_be), 32'd0);
    check("rst_bus_wdata", bus_wdata, 32'd0);
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_ld_data", ld_data, 32'd0);
    check("rst_ld_rdaddr", 32'(ld_rdaddr), 32'd0);
    check("rst_flags", {29'd0, ld_valid, misalign_err, bus_err}, 32'd0);

    //  rd    wr    f3     addr          wdata         rd     rdata         wait tag
    op(1'b1, 1'b0, 3'd2, 32'h0000_0100, 32'h0,        5'd5,  32'hDEADBEEF, 3,  "lw");
    op(1'b1, 1'b0, 3'd0, 32'h0000_0203, 32'h0,        5'd7,  32'h80112233, 1,  "lb");
    op(1'b1, 1'b0, 3'd4, 32'h0000_0203, 32'h0,        5'd8,  32'h80112233, 0,  "lbu");
    op(1'b0, 1'b1, 3'd1, 32'h0000_0042, 32'h0000ABCD, 5'd0,  32'h0,        0,  "sh");
    op(1'b1, 1'b0, 3'd2, 32'h0000_0102, 32'h0,        5'd3,  32'h0,        0,  "lw_mis");
    op(1'b1, 1'b0, 3'd3, 32'h0000_0100, 32'h0,        5'd3,  32'h0,        0,  "f3_011");
    op(1'b1, 1'b0, 3'd1, 32'h0000_0502, 32'h0,        5'd9,  32'h80011234, 2,  "lh");
    op(1'b1, 1'b0, 3'd5, 32'h0000_0500, 32'h0,        5'd10, 32'h80019234, 1,  "lhu");
    op(1'b1, 1'b0, 3'd1, 32'h0000_0501, 32'h0,        5'd9,  32'h0,        0,  "lh_mis");
    op(1'b1, 1'b1, 3'd0, 32'h0000_0007, 32'h12345699, 5'd0,  32'h0,        1,  "sb_prio");
    op(1'b1, 1'b1, 3'd4, 32'h0000_0008, 32'h0,        5'd0,  32'h0,        0,  "st_f3_100");
    op(1'b0, 1'b1, 3'd2, 32'h0000_0010, 32'hCAFEF00D, 5'd0,  32'h0,        2,  "sw");
    op(1'b0, 1'b1, 3'd1, 32'h0000_0013, 32'h0000BEEF, 5'd0,  32'h0,        0,  "sh_mis");
    op(1'b1, 1'b0, 3'd2, 32'h0000_0300, 32'h0,        5'd4,  32'h0,        -1, "timeout");

    // Ack while idle must not produce any event.
    @(posedge clk); #1;
    bus_ack = 1'b1; bus_rdata = 32'h5555AAAA;
    @(negedge clk);
    check("idle_ack_req", 32'(bus_req), 32'd0);
    check("idle_ack_stall", 32'(stall), 32'd0);
    @(posedge clk); #1 bus_ack = 1'b0;
    repeat (2) @(posedge clk);

    // Reset during BUSY abandons the access; a late ack is ignored.
    #1;
    stall_cnt = 0; req_cnt = 0;
    bus_q.push_back(model_bus(1'b0, 3'd2, 32'h0000_0400, 32'h0));
    req_valid = 1'b1; req_memrd = 1'b1; req_func3 = 3'd2; req_addr = 32'h400; req_rdaddr = 5'd11;
    @(posedge clk); #1;
    req_valid = 1'b0; req_memrd = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("rst_busy_req", 32'(bus_req), 32'd0);
    check("rst_busy_stall", 32'(stall), 32'd0);
    check("rst_busy_addr", bus_addr, 32'd0);
    repeat (2) @(posedge clk);
    #1 bus_ack = 1'b1; bus_rdata = 32'h12345678;
    @(posedge clk); #1 bus_ack = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("rst_busy_req_cycles", 32'(req_cnt), 32'd2);
    check("rst_busy_ld_data", ld_data, 32'd0);

    check("res_q_left", 32'(res_q.size()), 32'd0);
    check("bus_q_left", 32'(bus_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
